// File: rtl/dmem_bridge_pkg.sv
// Shared types and constants for the data-side bus bridge.
// Holds the bridge state encoding, access size codes and the kseg mapping helper.
package dmem_bridge_pkg;

    typedef enum logic [1:0] {
        DB_IDLE = 2'd0,
        DB_REQ  = 2'd1,
        DB_WAIT = 2'd2,
        DB_DONE = 2'd3
    } db_state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [31:0] KSEG_MASK = 32'h1FFF_FFFF;

    // kseg0/kseg1 (0x8000_0000..0xBFFF_FFFF) are unmapped windows onto
    // the low 512 MiB; everything else passes through untouched.
    function automatic logic [31:0] kseg_map(input logic [31:0] vaddr);
        if (vaddr[31:30] == 2'b10) begin
            return vaddr & KSEG_MASK;
        end
        return vaddr;
    endfunction

endpackage

// File: rtl/dmem_addr_map.sv
// Virtual-to-physical address map shared by the instruction and data bridges.
// Ports: i_vaddr (virtual byte address) -> o_paddr (physical byte address).
module dmem_addr_map
    import dmem_bridge_pkg::*;
#(
    parameter bit KSEG_MAP = 1'b1
) (
    input  logic [31:0] i_vaddr,
    output logic [31:0] o_paddr
);

    logic [31:0] w_mapped;

    assign w_mapped = kseg_map(i_vaddr);
    assign o_paddr  = KSEG_MAP ? w_mapped : i_vaddr;

endmodule

// File: rtl/dmem_bridge.sv
// Data-SRAM request to split addr/data handshake bus bridge with pipeline stall.
// Ports: clk/rst, flush_i, data_sram_* (pipeline side), data_stallreq_o, dbus_* (bus side).
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter bit KSEG_MAP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        data_stallreq_o,
    output logic        dbus_req,
    output logic        dbus_wr,
    output logic [1:0]  dbus_size,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_wstrb,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_addr_ok,
    input  logic        dbus_data_ok,
    input  logic [31:0] dbus_rdata
);

    db_state_t   r_state;
    db_state_t   w_next;
    logic [3:0]  r_wen;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_wr;
    logic        r_kill;
    logic [31:0] r_rdata;

    logic [31:0] w_paddr;
    logic        w_load;
    logic        w_set_kill;
    logic        w_clr_kill;
    logic        w_cap;
    logic        w_kill;
    logic        w_stall;
    logic        w_req;

    dmem_addr_map #(
        .KSEG_MAP (KSEG_MAP)
    ) u_map (
        .i_vaddr (data_sram_addr),
        .o_paddr (w_paddr)
    );

    // A flush arriving in the same cycle as data_ok still kills delivery.
    assign w_kill = r_kill | flush_i;

    always_comb begin
        w_next     = r_state;
        w_stall    = 1'b0;
        w_req      = 1'b0;
        w_load     = 1'b0;
        w_set_kill = 1'b0;
        w_clr_kill = 1'b0;
        w_cap      = 1'b0;
        unique case (r_state)
            DB_IDLE: begin
                w_stall = data_sram_en;
                if (data_sram_en && !flush_i) begin
                    w_load = 1'b1;
                    w_next = DB_REQ;
                end
            end
            DB_REQ: begin
                w_stall    = 1'b1;
                w_req      = 1'b1;
                w_set_kill = flush_i;
                if (dbus_addr_ok) begin
                    w_next = DB_WAIT;
                end
            end
            DB_WAIT: begin
                w_stall    = 1'b1;
                w_set_kill = flush_i;
                if (dbus_data_ok) begin
                    w_cap = !r_wr && !w_kill;
                    if (w_kill) begin
                        w_clr_kill = 1'b1;
                        w_next     = DB_IDLE;
                    end else begin
                        w_next = DB_DONE;
                    end
                end
            end
            // The request still on data_sram_en here is the completed one.
            DB_DONE: begin
                w_next = DB_IDLE;
            end
            default: begin
                w_next = DB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DB_IDLE;
            r_kill  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_clr_kill) begin
                r_kill <= 1'b0;
            end else if (w_set_kill) begin
                r_kill <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wen   <= '0;
            r_size  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wr    <= 1'b0;
        end else if (w_load) begin
            r_wen   <= data_sram_wen;
            r_size  <= data_sram_size;
            r_addr  <= w_paddr;
            r_wdata <= data_sram_wdata;
            r_wr    <= |data_sram_wen;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (w_cap) begin
            r_rdata <= dbus_rdata;
        end
    end

    assign data_sram_rdata = r_rdata;
    assign data_stallreq_o = w_stall;
    assign dbus_req        = w_req;
    assign dbus_wr         = r_wr;
    assign dbus_size       = r_size;
    assign dbus_addr       = r_addr;
    assign dbus_wstrb      = r_wen;
    assign dbus_wdata      = r_wdata;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: loads, stores, addr_ok backpressure, flush, reset.
// Drives inputs 1 time unit after each rising edge and checks 1 unit later.
module tb_dmem_bridge;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        data_stallreq_o;
    logic        dbus_req;
    logic        dbus_wr;
    logic [1:0]  dbus_size;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_wstrb;
    logic [31:0] dbus_wdata;
    logic        dbus_addr_ok;
    logic        dbus_data_ok;
    logic [31:0] dbus_rdata;

    int nerr = 0;
    int nchk = 0;
    int nacc = 0;

    dmem_bridge #(
        .KSEG_MAP (1'b1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .flush_i         (flush_i),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_size  (data_sram_size),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .data_stallreq_o (data_stallreq_o),
        .dbus_req        (dbus_req),
        .dbus_wr         (dbus_wr),
        .dbus_size       (dbus_size),
        .dbus_addr       (dbus_addr),
        .dbus_wstrb      (dbus_wstrb),
        .dbus_wdata      (dbus_wdata),
        .dbus_addr_ok    (dbus_addr_ok),
        .dbus_data_ok    (dbus_data_ok),
        .dbus_rdata      (dbus_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Accepted bus requests: one per REQ cycle that sees addr_ok.
    always @(posedge clk) begin
        if (!rst && dbus_req && dbus_addr_ok) begin
            nacc <= nacc + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin
        rst             = 1'b1;
        flush_i         = 1'b0;
        data_sram_en    = 1'b0;
        data_sram_wen   = 4'h0;
        data_sram_size  = 2'd0;
        data_sram_addr  = 32'h0;
        data_sram_wdata = 32'h0;
        dbus_addr_ok    = 1'b0;
        dbus_data_ok    = 1'b0;
        dbus_rdata      = 32'h0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_req", dbus_req, 0);
        chk("rst_stall", data_stallreq_o, 0);
        chk("rst_rdata", data_sram_rdata, 0);
        chk("rst_addr", dbus_addr, 0);
        chk("rst_wr", dbus_wr, 0);

        // Word load from kseg0
        step();
        data_sram_en   = 1'b1;
        data_sram_wen  = 4'h0;
        data_sram_size = 2'd2;
        data_sram_addr = 32'h8000_1004;
        #1;
        chk("ld_idle_stall", data_stallreq_o, 1);
        chk("ld_idle_req", dbus_req, 0);
        step();
        dbus_addr_ok = 1'b1;
        #1;
        chk("ld_req", dbus_req, 1);
        chk("ld_addr", dbus_addr, 32'h0000_1004);
        chk("ld_wr", dbus_wr, 0);
        chk("ld_size", dbus_size, 2);
        chk("ld_req_stall", data_stallreq_o, 1);
        step();
        dbus_addr_ok = 1'b0;
        #1;
        chk("ld_wait_req", dbus_req, 0);
        chk("ld_wait_stall", data_stallreq_o, 1);
        step();
        dbus_data_ok = 1'b1;
        dbus_rdata   = 32'hDEAD_BEEF;
        #1;
        chk("ld_wait2_stall", data_stallreq_o, 1);
        step();
        dbus_data_ok = 1'b0;
        dbus_rdata   = 32'h0;
        #1;
        chk("ld_done_stall", data_stallreq_o, 0);
        chk("ld_done_rdata", data_sram_rdata, 32'hDEAD_BEEF);
        step();
        data_sram_en = 1'b0;
        #1;
        chk("ld_idle_hold", data_sram_rdata, 32'hDEAD_BEEF);
        chk("ld_nacc", nacc, 1);

        // Byte store from kseg1 with addr_ok withheld 5 cycles
        data_sram_en    = 1'b1;
        data_sram_wen   = 4'b0100;
        data_sram_size  = 2'd0;
        data_sram_addr  = 32'hA000_0002;
        data_sram_wdata = 32'h00AB_0000;
        #1;
        chk("st_idle_stall", data_stallreq_o, 1);
        step();
        chk("st_wr", dbus_wr, 1);
        chk("st_wstrb", dbus_wstrb, 4'b0100);
        chk("st_size", dbus_size, 0);
        for (int i = 0; i < 5; i++) begin
            data_sram_wdata = 32'h1111_0000 + i;
            #1;
            chk("st_hold_req", dbus_req, 1);
            chk("st_hold_addr", dbus_addr, 32'h0000_0002);
            chk("st_hold_wdata", dbus_wdata, 32'h00AB_0000);
            chk("st_hold_stall", data_stallreq_o, 1);
            step();
        end
        data_sram_wdata = 32'h00AB_0000;
        dbus_addr_ok    = 1'b1;
        #1;
        chk("st_req_last", dbus_req, 1);
        chk("st_nacc_pre", nacc, 1);
        step();
        dbus_addr_ok = 1'b0;
        dbus_data_ok = 1'b1;
        dbus_rdata   = 32'h5555_5555;
        #1;
        chk("st_wait_stall", data_stallreq_o, 1);
        chk("st_wait_req", dbus_req, 0);
        step();
        dbus_data_ok = 1'b0;
        dbus_rdata   = 32'h0;
        #1;
        chk("st_done_stall", data_stallreq_o, 0);
        chk("st_rdata_keep", data_sram_rdata, 32'hDEAD_BEEF);
        step();
        data_sram_en = 1'b0;
        #1;
        chk("st_nacc", nacc, 2);

        // Half load from kseg2 (unmapped), flushed in WAIT
        data_sram_en   = 1'b1;
        data_sram_wen  = 4'h0;
        data_sram_size = 2'd1;
        data_sram_addr = 32'hC000_2002;
        step();
        dbus_addr_ok = 1'b1;
        #1;
        chk("fl_addr", dbus_addr, 32'hC000_2002);
        chk("fl_wr", dbus_wr, 0);
        step();
        dbus_addr_ok = 1'b0;
        flush_i      = 1'b1;
        #1;
        chk("fl_wait_stall", data_stallreq_o, 1);
        step();
        flush_i = 1'b0;
        #1;
        chk("fl_wait2_stall", data_stallreq_o, 1);
        step();
        dbus_data_ok = 1'b1;
        dbus_rdata   = 32'h1234_5678;
        #1;
        chk("fl_dok_stall", data_stallreq_o, 1);
        step();
        // Straight back to IDLE: a new request stalls at once
        dbus_data_ok   = 1'b0;
        dbus_rdata     = 32'h0;
        data_sram_addr = 32'h9000_0010;
        data_sram_size = 2'd2;
        #1;
        chk("fl_idle_stall", data_stallreq_o, 1);
        chk("fl_idle_req", dbus_req, 0);
        chk("fl_rdata_keep", data_sram_rdata, 32'hDEAD_BEEF);
        chk("fl_nacc", nacc, 3);

        // Back-to-back loads with en held across DONE
        step();
        dbus_addr_ok = 1'b1;
        #1;
        chk("bb1_req", dbus_req, 1);
        chk("bb1_addr", dbus_addr, 32'h1000_0010);
        step();
        dbus_addr_ok = 1'b0;
        dbus_data_ok = 1'b1;
        dbus_rdata   = 32'hCAFE_F00D;
        #1;
        chk("bb1_wait_stall", data_stallreq_o, 1);
        step();
        dbus_data_ok = 1'b0;
        dbus_rdata   = 32'h0;
        #1;
        chk("bb1_done_stall", data_stallreq_o, 0);
        chk("bb1_done_req", dbus_req, 0);
        chk("bb1_rdata", data_sram_rdata, 32'hCAFE_F00D);
        step();
        data_sram_addr = 32'h8000_0020;
        #1;
        chk("bb2_idle_stall", data_stallreq_o, 1);
        chk("bb2_idle_req", dbus_req, 0);
        chk("bb2_nacc_pre", nacc, 4);
        step();
        dbus_addr_ok = 1'b1;
        #1;
        chk("bb2_req", dbus_req, 1);
        chk("bb2_addr", dbus_addr, 32'h0000_0020);
        step();
        dbus_addr_ok = 1'b0;
        #1;
        chk("bb2_nacc", nacc, 5);
        chk("bb2_wait_stall", data_stallreq_o, 1);

        // Reset in WAIT
        rst = 1'b1;
        step();
        rst          = 1'b0;
        data_sram_en = 1'b0;
        #1;
        chk("mr_stall", data_stallreq_o, 0);
        chk("mr_req", dbus_req, 0);
        chk("mr_rdata", data_sram_rdata, 0);
        chk("mr_addr", dbus_addr, 0);
        chk("mr_wr", dbus_wr, 0);
        chk("mr_wstrb", dbus_wstrb, 0);
        chk("mr_wdata", dbus_wdata, 0);
        chk("mr_size", dbus_size, 0);

        // New word store after reset
        data_sram_en    = 1'b1;
        data_sram_wen   = 4'hF;
        data_sram_size  = 2'd2;
        data_sram_addr  = 32'h0000_0100;
        data_sram_wdata = 32'h1122_3344;
        step();
        dbus_addr_ok = 1'b1;
        #1;
        chk("pr_req", dbus_req, 1);
        chk("pr_addr", dbus_addr, 32'h0000_0100);
        chk("pr_wstrb", dbus_wstrb, 4'hF);
        chk("pr_wdata", dbus_wdata, 32'h1122_3344);
        chk("pr_wr", dbus_wr, 1);
        step();
        dbus_addr_ok = 1'b0;
        dbus_data_ok = 1'b1;
        step();
        dbus_data_ok = 1'b0;
        #1;
        chk("pr_done_stall", data_stallreq_o, 0);
        step();
        data_sram_en = 1'b0;
        #1;
        chk("pr_nacc", nacc, 6);
        chk("pr_idle_req", dbus_req, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
